// File: rtl/div_issue_ctrl_pkg.sv
// div_ctrl_pkg: shared definitions for the EX-stage divider issue controller.
//   - div_state_e : controller FSM states
//   - TAG_W_DEF   : default width of the destination-register tag
//   - OP_SIGNED / OP_MOD : encodings of the req_signed / req_mod request bits
//   - sel_result  : picks quotient or remainder according to the mod bit
package div_ctrl_pkg;

  localparam int TAG_W_DEF = 5;

  // req_signed = OP_SIGNED selects DIV.W/MOD.W; req_mod = OP_MOD returns the remainder.
  localparam logic OP_SIGNED = 1'b1;
  localparam logic OP_MOD    = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    BUSY  = 3'd2,
    DRAIN = 3'd3,
    HOLD  = 3'd4
  } div_state_e;

  function automatic logic [31:0] sel_result(input logic mod, input logic [31:0] q,
                                             input logic [31:0] r);
    return (mod == OP_MOD) ? r : q;
  endfunction

endpackage

// File: rtl/div_issue_ctrl_if.sv
// div_issue_ctrl_if: bundles the three handshakes of the divider issue controller.
//   request side : req_valid/req_ready + operands and tag from EX, ex_stall back to EX
//   core side    : core_start/core_ready + operands to the divider core,
//                  core_done/core_q/core_r back from it
//   result side  : res_valid/res_ready + res_data/res_tag towards MEM
// Modport master is the controller; slave is the surrounding pipeline/core.
interface div_issue_ctrl_if
  import div_ctrl_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF
) ();

  logic             req_valid;
  logic             req_ready;
  logic             req_signed;
  logic             req_mod;
  logic [31:0]      req_x;
  logic [31:0]      req_y;
  logic [TAG_W-1:0] req_tag;
  logic             ex_stall;

  logic             core_start;
  logic             core_ready;
  logic             core_signed;
  logic [31:0]      core_x;
  logic [31:0]      core_y;
  logic             core_done;
  logic [31:0]      core_q;
  logic [31:0]      core_r;

  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;

  modport master (
    input  req_valid, req_signed, req_mod, req_x, req_y, req_tag,
    output req_ready, ex_stall,
    output core_start, core_signed, core_x, core_y,
    input  core_ready, core_done, core_q, core_r,
    output res_valid, res_data, res_tag,
    input  res_ready
  );

  modport slave (
    output req_valid, req_signed, req_mod, req_x, req_y, req_tag,
    input  req_ready, ex_stall,
    input  core_start, core_signed, core_x, core_y,
    output core_ready, core_done, core_q, core_r,
    input  res_valid, res_data, res_tag,
    output res_ready
  );

endinterface

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: sequences the shared 32-bit divider core for EX.
//   clk    : clock
//   resetn : synchronous active-low reset (does not reset the divider core)
//   flush  : exception/ERTN cancel from WB
//   bus    : div_issue_ctrl_if.master - request (EX), core and result (MEM) handshakes
// One divide at a time: IDLE latches the request, ISSUE hands operands to the
// core, BUSY waits for core_done, HOLD presents the result to MEM. A zero
// divisor bypasses the core entirely. DRAIN swallows the done pulse of an
// operation that was flushed while the core was still working on it.
module div_issue_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  div_issue_ctrl_if.master bus
);

  div_state_e       state_q, state_d;
  logic             signed_q, signed_d;
  logic             mod_q, mod_d;
  logic [31:0]      x_q, x_d;
  logic [31:0]      y_q, y_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      data_q, data_d;

  logic             req_ready;
  logic             core_start;
  logic             res_valid;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      signed_q <= 1'b0;
      mod_q    <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      tag_q    <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      signed_q <= signed_d;
      mod_q    <= mod_d;
      x_q      <= x_d;
      y_q      <= y_d;
      tag_q    <= tag_d;
      data_q   <= data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    signed_d   = signed_q;
    mod_d      = mod_q;
    x_d        = x_q;
    y_d        = y_q;
    tag_d      = tag_q;
    data_d     = data_q;
    req_ready  = 1'b0;
    core_start = 1'b0;
    res_valid  = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid && !flush) begin
          signed_d = bus.req_signed;
          mod_d    = bus.req_mod;
          x_d      = bus.req_x;
          y_d      = bus.req_y;
          tag_d    = bus.req_tag;
          if (bus.req_y == 32'd0) begin
            // Divide by zero never reaches the core: quotient 0, remainder x.
            data_d  = sel_result(bus.req_mod, 32'd0, bus.req_x);
            state_d = HOLD;
          end else begin
            state_d = ISSUE;
          end
        end
      end

      ISSUE: begin
        // Gating with flush keeps a cancelled op from ever starting the core.
        core_start = !flush;
        if (flush) begin
          state_d = IDLE;
        end else if (bus.core_ready) begin
          state_d = BUSY;
        end
      end

      BUSY: begin
        if (flush) begin
          // If done arrives with the flush there is nothing left to drain.
          state_d = bus.core_done ? IDLE : DRAIN;
        end else if (bus.core_done) begin
          data_d  = sel_result(mod_q, bus.core_q, bus.core_r);
          state_d = HOLD;
        end
      end

      DRAIN: begin
        // Flush is irrelevant here; only the stale done pulse releases us.
        if (bus.core_done) begin
          state_d = IDLE;
        end
      end

      HOLD: begin
        res_valid = 1'b1;
        if (flush || bus.res_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready   = req_ready;
  assign bus.core_start  = core_start;
  assign bus.core_signed = (signed_q == OP_SIGNED);
  assign bus.core_x      = x_q;
  assign bus.core_y      = y_q;
  assign bus.res_valid   = res_valid;
  assign bus.res_data    = data_q;
  assign bus.res_tag     = tag_q;

  // EX leaves the stall in the very cycle MEM takes the result.
  assign bus.ex_stall = bus.req_valid & ~(res_valid & bus.res_ready) & ~flush;

  // The core may only signal done while an operation is outstanding.
  a_done_protocol: assert property (@(posedge clk) disable iff (!resetn)
    !(bus.core_done && (state_q == IDLE || state_q == ISSUE || state_q == HOLD)));

endmodule

// File: tb/tb_div_issue_ctrl.sv
module tb_div_issue_ctrl;
  import div_ctrl_pkg::*;

  logic clk;
  logic resetn;
  logic flush;
  logic core_kill;
  int   lat;

  int total;
  int bad;

  logic [31:0] exp_data_q[$];
  logic [4:0]  exp_tag_q[$];

  div_issue_ctrl_if #(.TAG_W(5)) bus ();

  div_issue_ctrl #(.TAG_W(5)) dut (
    .clk    (clk),
    .resetn (resetn),
    .flush  (flush),
    .bus    (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference divide: truncating signed/unsigned division, y != 0.
  function automatic logic [31:0] calc(input logic s, input logic m, input logic [31:0] a,
                                       input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return m ? r : q;
  endfunction

  // Divider core model with configurable latency.
  logic        m_busy;
  int          m_cnt;
  logic        m_s;
  logic [31:0] m_x;
  logic [31:0] m_y;

  assign bus.core_ready = ~m_busy;

  always @(posedge clk) begin
    bus.core_done <= 1'b0;
    if (core_kill) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
    end else if (m_busy) begin
      if (m_cnt <= 1) begin
        m_busy        <= 1'b0;
        bus.core_done <= 1'b1;
        bus.core_q    <= calc(m_s, 1'b0, m_x, m_y);
        bus.core_r    <= calc(m_s, 1'b1, m_x, m_y);
      end
      m_cnt <= m_cnt - 1;
    end else if (bus.core_start && bus.core_ready) begin
      m_busy <= 1'b1;
      m_cnt  <= lat;
      m_s    <= bus.core_signed;
      m_x    <= bus.core_x;
      m_y    <= bus.core_y;
    end
  end

  // Present a request on the next falling edge; it is latched at the following rising edge.
  task automatic drive_req(input logic s, input logic m, input logic [31:0] x,
                           input logic [31:0] y, input logic [4:0] tag);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_signed = s;
    bus.req_mod    = m;
    bus.req_x      = x;
    bus.req_y      = y;
    bus.req_tag    = tag;
  endtask

  // Wait (bounded) for res_valid; n = cycles waited, -1 on timeout.
  task automatic wait_valid(input int max, output int n);
    n = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (bus.res_valid === 1'b1) begin
        n = i + 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    core_kill = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (dut.state_q !== IDLE) begin bad++; $display("FAIL reset_state got=%0d want=%0d", dut.state_q, IDLE); end
    total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b want=1", bus.req_ready); end
    total++; if (bus.core_start !== 1'b0) begin bad++; $display("FAIL reset_core_start got=%b want=0", bus.core_start); end
    total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b want=0", bus.res_valid); end
    total++; if (bus.ex_stall !== 1'b0) begin bad++; $display("FAIL reset_ex_stall got=%b want=0", bus.ex_stall); end
    total++; if (bus.res_data !== 32'd0 || bus.res_tag !== 5'd0) begin bad++; $display("FAIL reset_res got=%h/%h want=0/0", bus.res_data, bus.res_tag); end
    total++; if (bus.core_x !== 32'd0 || bus.core_y !== 32'd0) begin bad++; $display("FAIL reset_core_xy got=%h/%h want=0/0", bus.core_x, bus.core_y); end
    resetn = 1'b1;
    core_kill = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_signed_div;
    logic [31:0] ed;
    logic [4:0]  et;
    logic        stall_ok;
    logic        found;
    lat = 8;
    drive_req(1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 5'd3);
    exp_data_q.push_back(32'hFFFF_FFFD);
    exp_tag_q.push_back(5'd3);
    @(negedge clk);
    total++; if (bus.core_start !== 1'b1) begin bad++; $display("FAIL sdiv_core_start got=%b want=1", bus.core_start); end
    total++; if (bus.core_signed !== 1'b1) begin bad++; $display("FAIL sdiv_core_signed got=%b want=1", bus.core_signed); end
    total++; if (bus.core_x !== 32'hFFFF_FFF9 || bus.core_y !== 32'd2) begin bad++; $display("FAIL sdiv_core_xy got=%h/%h want=fffffff9/2", bus.core_x, bus.core_y); end
    stall_ok = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.ex_stall !== 1'b1) stall_ok = 1'b0;
      if (bus.core_done === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL sdiv_done_timeout got=%b want=1", found); end
    total++; if (stall_ok !== 1'b1) begin bad++; $display("FAIL sdiv_ex_stall_held got=%b want=1", stall_ok); end
    total++; if (bus.res_valid !== 1'b0) begin bad++; $display("FAIL sdiv_valid_early got=%b want=0", bus.res_valid); end
    @(negedge clk);
    total++; if (bus.res_valid !== 1'b1) begin bad++; $display("FAIL sdiv_valid_latency got=%b want=1", bus.res_valid); end
    ed = exp_data_q.pop_front();
    et = exp_tag_q.pop_front();
    total++; if (bus.res_data !== ed) begin bad++; $display("FAIL sdiv_data got=%h want=%h", bus.res_data, ed); end
    total++; if (bus.res_tag !== et) begin bad++; $display("FAIL sdiv_tag got=%h want=%h", bus.res_tag, et); end
    bus.res_ready = 1'b1;
    #1;
    total++; if (bus.ex_stall !== 1'b0) begin bad++; $display("FAIL sdiv_stall_release got=%b want=0", bus.ex_stall); end
    @(negedge clk);
    bus.res_ready = 1'b0;
    bus.req_valid = 1'b0;
    total++; if (bus.res_valid !== 1'b0 || dut.state_q !== IDLE) begin bad++; $display("FAIL sdiv_after_hs got=%b/%0d want=0/%0d", bus.res_valid, dut.state_q, IDLE); end
  endtask

  task automatic test_signed_mod_unsigned;
    logic        t_s[2]   = '{1'b1, 1'b0};
    logic        t_m[2]   = '{1'b1, 1'b0};
    logic [31:0] t_x[2]   = '{32'hFFFF_FFF9, 32'hFFFF_FFFF};
    logic [31:0] t_y[2]   = '{32'd2, 32'd16};
    logic [31:0] t_exp[2] = '{32'hFFFF_FFFF, 32'h0FFF_FFFF};
    logic [31:0] ed;
    logic [4:0]  et;
    int n;
    lat = 5;
    for (int k = 0; k < 2; k++) begin
      drive_req(t_s[k], t_m[k], t_x[k], t_y[k], 5'(7 + k));
      exp_data_q.push_back(t_exp[k]);
      exp_tag_q.push_back(5'(7 + k));
      @(negedge clk);
      total++; if (bus.core_signed !== t_s[k]) begin bad++; $display("FAIL op%0d_core_signed got=%b want=%b", k, bus.core_signed, t_s[k]); end
      wait_valid(30, n);
      total++; if (n < 0) begin bad++; $display("FAIL op%0d_valid_timeout got=%0d want>0", k, n); end
      ed = exp_data_q.pop_front();
      et = exp_tag_q.pop_front();
      total++; if (bus.res_data !== ed || bus.res_tag !== et) begin bad++; $display("FAIL op%0d_result got=%h/%h want=%h/%h", k, bus.res_data, bus.res_tag, ed, et); end
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic test_div_zero;
    logic [31:0] ed;
    for (int k = 0; k < 2; k++) begin
      drive_req(1'b1, (k == 0), 32'h0000_1234, 32'd0, 5'd9);
      exp_data_q.push_back((k == 0) ? 32'h0000_1234 : 32'd0);
      exp_tag_q.push_back(5'd9);
      @(negedge clk);
      total++; if (bus.res_valid !== 1'b1) begin bad++; $display("FAIL dz%0d_valid got=%b want=1", k, bus.res_valid); end
      total++; if (bus.core_start !== 1'b0) begin bad++; $display("FAIL dz%0d_core_start got=%b want=0", k, bus.core_start); end
      ed = exp_data_q.pop_front();
      void'(exp_tag_q.pop_front());
      total++; if (bus.res_data !== ed) begin bad++; $display("FAIL dz%0d_data got=%h want=%h", k, bus.res_data, ed); end
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      bus.req_valid = 1'b0;
      total++; if (bus.core_start !== 1'b0 || dut.state_q !== IDLE) begin bad++; $display("FAIL dz%0d_after got=%b/%0d want=0/%0d", k, bus.core_start, dut.state_q, IDLE); end
    end
  endtask

  task automatic test_flush_drain;
    logic drain_ok;
    logic found;
    logic [31:0] ed;
    int n;
    lat = 8;
    drive_req(1'b0, 1'b0, 32'd1000, 32'd3, 5'd4);
    @(negedge clk);                 // ISSUE
    repeat (3) @(negedge clk);      // three cycles into BUSY
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    bus.req_x   = 32'd100;
    bus.req_y   = 32'd7;
    bus.req_tag = 5'd12;
    exp_data_q.push_back(32'd14);
    exp_tag_q.push_back(5'd12);
    drain_ok = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (dut.state_q !== DRAIN || bus.req_ready !== 1'b0 || bus.res_valid !== 1'b0) drain_ok = 1'b0;
      if (bus.core_done === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL drain_done_timeout got=%b want=1", found); end
    total++; if (drain_ok !== 1'b1) begin bad++; $display("FAIL drain_hold got=%b want=1", drain_ok); end
    @(negedge clk);
    total++; if (dut.state_q !== IDLE) begin bad++; $display("FAIL drain_exit got=%0d want=%0d", dut.state_q, IDLE); end
    wait_valid(40, n);
    total++; if (n < 0) begin bad++; $display("FAIL drain_new_timeout got=%0d want>0", n); end
    ed = exp_data_q.pop_front();
    void'(exp_tag_q.pop_front());
    total++; if (bus.res_data !== ed || bus.res_tag !== 5'd12) begin bad++; $display("FAIL drain_new_data got=%h/%h want=%h/0c", bus.res_data, bus.res_tag, ed); end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    bus.req_valid = 1'b0;
  endtask

  task automatic test_flush_with_done;
    logic found;
    logic quiet;
    lat = 4;
    drive_req(1'b0, 1'b0, 32'd50, 32'd5, 5'd1);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.core_done === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    total++; if (found !== 1'b1) begin bad++; $display("FAIL fdone_timeout got=%b want=1", found); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    bus.req_valid = 1'b0;
    total++; if (dut.state_q !== IDLE) begin bad++; $display("FAIL fdone_state got=%0d want=%0d", dut.state_q, IDLE); end
    quiet = 1'b1;
    repeat (3) begin
      if (bus.res_valid !== 1'b0) quiet = 1'b0;
      @(negedge clk);
    end
    total++; if (quiet !== 1'b1) begin bad++; $display("FAIL fdone_no_valid got=%b want=1", quiet); end
  endtask

  task automatic test_flush_hold;
    int n;
    lat = 2;
    drive_req(1'b1, 1'b1, 32'd77, 32'd10, 5'd2);
    wait_valid(20, n);
    total++; if (n < 0) begin bad++; $display("FAIL fhold_timeout got=%0d want>0", n); end
    bus.res_ready = 1'b1;
    flush = 1'b1;
    #1;
    total++; if (bus.ex_stall !== 1'b0) begin bad++; $display("FAIL fhold_stall got=%b want=0", bus.ex_stall); end
    @(negedge clk);
    flush = 1'b0;
    bus.res_ready = 1'b0;
    bus.req_valid = 1'b0;
    total++; if (bus.res_valid !== 1'b0 || dut.state_q !== IDLE) begin bad++; $display("FAIL fhold_drop got=%b/%0d want=0/%0d", bus.res_valid, dut.state_q, IDLE); end
  endtask

  task automatic test_backpressure;
    logic stable;
    logic [31:0] ed;
    int n;
    lat = 3;
    drive_req(1'b0, 1'b1, 32'd1001, 32'd10, 5'd21);
    exp_data_q.push_back(32'd1);
    exp_tag_q.push_back(5'd21);
    wait_valid(20, n);
    total++; if (n < 0) begin bad++; $display("FAIL bp_timeout got=%0d want>0", n); end
    ed = exp_data_q.pop_front();
    void'(exp_tag_q.pop_front());
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (bus.res_valid !== 1'b1 || bus.res_data !== ed || bus.ex_stall !== 1'b1) stable = 1'b0;
      @(negedge clk);
    end
    total++; if (stable !== 1'b1) begin bad++; $display("FAIL bp_stable got=%b want=1 (data=%h exp=%h)", stable, bus.res_data, ed); end
    total++; if (bus.res_data !== ed || bus.res_tag !== 5'd21) begin bad++; $display("FAIL bp_data got=%h/%h want=%h/15", bus.res_data, bus.res_tag, ed); end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset_mid_busy;
    lat = 8;
    drive_req(1'b1, 1'b0, 32'd900, 32'd9, 5'd30);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    total++; if (dut.state_q !== BUSY) begin bad++; $display("FAIL rst_busy_pre got=%0d want=%0d", dut.state_q, BUSY); end
    resetn = 1'b0;
    core_kill = 1'b1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    total++; if (dut.state_q !== IDLE || bus.req_ready !== 1'b1) begin bad++; $display("FAIL rst_busy_state got=%0d/%b want=%0d/1", dut.state_q, bus.req_ready, IDLE); end
    total++; if (bus.core_start !== 1'b0 || bus.res_valid !== 1'b0 || bus.ex_stall !== 1'b0) begin bad++; $display("FAIL rst_busy_ctl got=%b%b%b want=000", bus.core_start, bus.res_valid, bus.ex_stall); end
    total++; if (bus.core_x !== 32'd0 || bus.core_y !== 32'd0 || bus.res_data !== 32'd0 || bus.res_tag !== 5'd0) begin bad++; $display("FAIL rst_busy_regs got=%h/%h/%h/%h want=0", bus.core_x, bus.core_y, bus.res_data, bus.res_tag); end
    resetn = 1'b1;
    core_kill = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic        s;
    logic        m;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] ed;
    logic [4:0]  et;
    int n;
    for (int k = 0; k < 10; k++) begin
      s = 1'($urandom_range(0, 1));
      m = 1'($urandom_range(0, 1));
      x = $urandom;
      y = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
      if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) y = 32'd1;
      lat = $urandom_range(1, 6);
      drive_req(s, m, x, y, 5'(k));
      exp_data_q.push_back((y == 32'd0) ? (m ? x : 32'd0) : calc(s, m, x, y));
      exp_tag_q.push_back(5'(k));
      wait_valid(30, n);
      total++; if (n < 0) begin bad++; $display("FAIL b2b%0d_timeout got=%0d want>0", k, n); end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ed = exp_data_q.pop_front();
      et = exp_tag_q.pop_front();
      total++; if (bus.res_data !== ed || bus.res_tag !== et) begin bad++; $display("FAIL b2b%0d_result s=%b m=%b x=%h y=%h got=%h/%h want=%h/%h", k, s, m, x, y, bus.res_data, bus.res_tag, ed, et); end
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      bus.req_valid = 1'b0;
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    resetn = 1'b0;
    flush = 1'b0;
    core_kill = 1'b1;
    lat = 4;
    bus.req_valid = 1'b0;
    bus.req_signed = 1'b0;
    bus.req_mod = 1'b0;
    bus.req_x = 32'd0;
    bus.req_y = 32'd0;
    bus.req_tag = 5'd0;
    bus.res_ready = 1'b0;

    test_reset;
    test_signed_div;
    test_signed_mod_unsigned;
    test_div_zero;
    test_flush_drain;
    test_flush_with_done;
    test_flush_hold;
    test_backpressure;
    test_reset_mid_busy;
    test_back_to_back;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
